branch_predictor: RTL
=====================

// Module: branch_predictor
// PURPOSE
//  Direction predictor for the 5-stage pipeline, on the other end of the EX-stage branch
//  comparator: predicts taken/not-taken at IF and consumes the resolved outcome from EX.
//  - Holds a table of 2-bit saturating counters (BHT), indexed by PC.
//  - Trains the table on every resolved branch.
//  - On a wrong prediction, raises a registered one-cycle redirect with the correct PC.
//  - Maintains branch and mispredict counters for performance monitoring.
// PARAMETERS
//  INDEX_BITS   6      BHT index width; table has 2**INDEX_BITS entries
//  CTR_INIT     2'b01  counter reset value (weakly not-taken)
// PORTS
//  clk              in   1   clock, all state updates on rising edge
//  rst_n            in   1   asynchronous active-low reset
//  if_valid         in   1   IF-stage lookup request
//  if_pc            in   32  PC of instruction being fetched
//  pred_taken       out  1   predicted direction for if_pc (combinational)
//  ex_valid         in   1   EX-stage instruction valid
//  ex_branch        in   1   EX instruction is a conditional branch
//  ex_kill          in   1   EX instruction is wrong-path; ignore its resolution
//  ex_pc            in   32  PC of resolving branch
//  ex_taken         in   1   resolved outcome from branch comparator
//  ex_pred_taken    in   1   prediction made for this branch at IF, piped to EX
//  ex_target        in   32  computed branch target (ex_pc + imm)
//  redirect_valid   out  1   one-cycle pulse: flush younger stages, fetch redirect_pc
//  redirect_pc      out  32  correct next PC after a mispredict
//  branch_cnt       out  32  number of resolved branches
//  mispredict_cnt   out  32  number of mispredicted branches
// BEHAVIOUR
//  - Reset (async, rst_n=0): all counters <= CTR_INIT; redirect_valid=0; redirect_pc=0;
//    branch_cnt=0; mispredict_cnt=0. Reset mid-operation discards any pending redirect.
//  - Index: idx = pc[INDEX_BITS+1:2]; PC bits [1:0] and upper bits are ignored (no tags).
//  - Lookup (combinational, 0-cycle): pred_taken = if_valid & ctr[idx(if_pc)][1].
//    pred_taken = 0 when if_valid = 0.
//  - Resolve event R = ex_valid & ex_branch & ~ex_kill. With R:
//      - Counter update at the next edge: ctr <= sat(ctr + 1) if ex_taken,
//        else sat(ctr - 1). Range is 0..3, so 3+1 = 3 and 0-1 = 0.
//      - branch_cnt increments by 1; it saturates at 32'hFFFF_FFFF, no wrap.
//      - Mispredict M = R & (ex_taken != ex_pred_taken). On M, mispredict_cnt increments
//        by 1 (saturating), and at the next edge redirect_valid <= 1 with
//        redirect_pc <= ex_taken ? ex_target : ex_pc + 32'd4 (mod 2^32).
//      - Without M, redirect_valid <= 0 at the next edge. redirect_pc holds its last value.
//  - With no R, the table and counters are unchanged and redirect_valid <= 0.
//  - Redirect latency: exactly 1 cycle after the EX cycle of the mispredicted branch.
//    The pulse is never longer than 1 cycle unless back-to-back M events occur.
//  - Same-cycle lookup and update to the same index: pred_taken uses the OLD counter
//    (no write-to-read bypass). The new value is visible from the next cycle.
//  - ex_pred_taken is trusted as given; the table is NOT re-read at EX for comparison.
//  - Flushing younger wrong-path instructions (asserting ex_kill for them) is the
//    pipeline control's job; the predictor acts only on ex_kill.
// TESTING
//  1. Reset, then lookup if_pc=0x0000_0040 -> pred_taken=0 (ctr=01); counters=0.
//  2. Resolve ex_pc=0x40, taken, ex_pred_taken=0, ex_target=0x100
//     -> next cycle redirect_valid=1 for 1 cycle, redirect_pc=0x100, mispredict_cnt=1;
//     after the update, lookup 0x40 -> pred_taken=1.
//  3. Three more taken resolves of 0x40 with ex_pred_taken=1
//     -> no redirect; counter saturates at 11; branch_cnt=4.
//     Then not-taken with ex_pred_taken=1 -> redirect_pc=0x44, pred still 1 (ctr=10).
//  4. Aliasing: update 0x40 and lookup 0x140 (INDEX_BITS=6) -> same entry.
//     Lookup 0x40 in the same cycle as its update -> returns pre-update value.
//  5. ex_kill=1 with a mispredicting resolve -> no redirect, no counter or table change.
//     ex_pc=0xFFFF_FFFC not-taken mispredict -> redirect_pc=0x0000_0000 (wrap).
//  6. Assert rst_n=0 in the cycle after a mispredict -> redirect_valid drops immediately;
//     all counters and the table return to reset values.

Source files
------------

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//   Direction predictor for the 5-stage pipeline. A table of 2-bit saturating
//   counters (BHT), indexed by PC bits [INDEX_BITS+1:2] with no tags, is read
//   combinationally at IF and trained by resolved branches from EX. A wrong
//   prediction produces a registered one-cycle redirect carrying the correct
//   next PC. Branch and mispredict event counters saturate at all-ones.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   if_valid, if_pc                  IF lookup request and fetch PC
//   pred_taken                       predicted direction (combinational)
//   ex_valid, ex_branch, ex_kill     EX qualifiers for a resolving branch
//   ex_pc, ex_taken, ex_pred_taken   resolving branch PC, outcome, IF prediction
//   ex_target                        computed branch target
//   redirect_valid, redirect_pc      registered mispredict redirect
//   branch_cnt, mispredict_cnt       performance counters
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int         INDEX_BITS = 6,
    parameter logic [1:0] CTR_INIT   = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    input  logic        ex_valid,
    input  logic        ex_branch,
    input  logic        ex_kill,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_target,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispredict_cnt
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [1:0]            bht [ENTRIES];
    logic [INDEX_BITS-1:0] if_idx;
    logic [INDEX_BITS-1:0] ex_idx;
    logic                  resolve_p0;
    logic                  mispredict_p0;
    logic [31:0]           fix_pc_p0;
    logic                  if_pc_unused;
    logic                  ex_pc_unused;

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'b11) ? v : v + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec2(input logic [1:0] v);
        return (v == 2'b00) ? v : v - 2'b01;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Untagged table: PC bits outside the index field only alias entries.
    assign if_idx       = if_pc[INDEX_BITS+1:2];
    assign ex_idx       = ex_pc[INDEX_BITS+1:2];
    assign if_pc_unused = ^{if_pc[31:INDEX_BITS+2], if_pc[1:0]};
    assign ex_pc_unused = ^{ex_pc[31:INDEX_BITS+2], ex_pc[1:0]};

    // IF lookup reads the registered table, so a same-cycle update is not
    // bypassed: the new counter becomes visible on the following cycle.
    assign pred_taken = if_valid & bht[if_idx][1];

    // EX resolve: the prediction carried down the pipe is trusted as-is.
    assign resolve_p0    = ex_valid & ex_branch & ~ex_kill;
    assign mispredict_p0 = resolve_p0 & (ex_taken != ex_pred_taken);
    assign fix_pc_p0     = ex_taken ? ex_target : ex_pc + 32'd4;

    // ---- EX -> registered state (table, redirect, counters) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht[i] <= CTR_INIT;
            end
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            branch_cnt     <= 32'd0;
            mispredict_cnt <= 32'd0;
        end else begin
            redirect_valid <= mispredict_p0;
            if (resolve_p0) begin
                bht[ex_idx] <= ex_taken ? sat_inc2(bht[ex_idx]) : sat_dec2(bht[ex_idx]);
                branch_cnt  <= sat_inc32(branch_cnt);
            end
            if (mispredict_p0) begin
                redirect_pc    <= fix_pc_p0;
                mispredict_cnt <= sat_inc32(mispredict_cnt);
            end
        end
    end

endmodule
